// File: rtl/card_shoe_if.sv
// Request/response bundle between a round controller and card_shoe.
// Build option CARD_SHOE_FORCE_EN adds the forced-rank inputs.
interface card_shoe_if;
  // deal_req is taken only in a cycle where deal_ready=1; card_valid is a
  // one-cycle pulse and card_value/card_dest hold until the next pulse.
  logic       deal_req;
  logic       deal_dest;
  logic       shuffle;
`ifdef CARD_SHOE_FORCE_EN
  logic       force_en;
  logic [3:0] force_idx;
`endif
  logic       deal_ready;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_dest;
  logic [8:0] cards_remaining;
  logic       reshuffle_due;
  logic       shoe_empty;
  logic [1:0] dbg_state;

  modport master (
`ifdef CARD_SHOE_FORCE_EN
    output force_en, force_idx,
`endif
    output deal_req, deal_dest, shuffle,
    input  deal_ready, card_valid, card_value, card_dest,
    input  cards_remaining, reshuffle_due, shoe_empty, dbg_state
  );

  modport slave (
`ifdef CARD_SHOE_FORCE_EN
    input  force_en, force_idx,
`endif
    input  deal_req, deal_dest, shuffle,
    output deal_ready, card_valid, card_value, card_dest,
    output cards_remaining, reshuffle_due, shoe_empty, dbg_state
  );
endinterface

// File: rtl/card_shoe.sv
// Finite multi-deck shoe dealing LFSR-picked cards without replacement.
// Build option CARD_SHOE_FORCE_EN lets force_idx choose the starting rank.
module card_shoe #(
  parameter int          NUM_DECKS  = 1,
  parameter int          CUT_REMAIN = 15,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  card_shoe_if.slave  bus
);

  localparam logic [15:0] SEED_NZ    = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [5:0]  FULL_COUNT = 6'(4 * NUM_DECKS);
  localparam logic [8:0]  FULL_SHOE  = 9'(52 * NUM_DECKS);
  localparam logic [8:0]  CUT        = 9'(CUT_REMAIN);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_PROBE, S_SHUFFLE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  counts_q [13];
  logic [5:0]  counts_d [13];
  logic [8:0]  rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic        dest_q, dest_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [3:0]  value_q, value_d;
  logic        cdest_q, cdest_d;
  logic [3:0]  req_idx;
  logic        deal_ready;

  function automatic logic [3:0] value_of(input logic [3:0] i);
    if (i <= 4'd7)       return i + 4'd2;
    else if (i <= 4'd11) return 4'd10;
    else                 return 4'd11;
  endfunction

  // Taps 16,14,13,11 shifting right; a non-zero state never reaches zero.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    req_idx = (lfsr_q[3:0] >= 4'd13) ? lfsr_q[3:0] - 4'd13 : lfsr_q[3:0];
`ifdef CARD_SHOE_FORCE_EN
    if (bus.force_en) req_idx = (bus.force_idx >= 4'd13) ? 4'd12 : bus.force_idx;
`endif
  end

  assign deal_ready = (state_q == S_IDLE) && (rem_q != 9'd0);

  always_comb begin
    state_d  = state_q;
    counts_d = counts_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    dest_d   = dest_q;
    pend_d   = pend_q;
    valid_d  = 1'b0;
    value_d  = value_q;
    cdest_d  = cdest_q;
    case (state_q)
      S_IDLE: begin
        if (bus.shuffle || pend_q) begin
          state_d = S_SHUFFLE;
        end else if (bus.deal_req && deal_ready) begin
          dest_d  = bus.deal_dest;
          idx_d   = req_idx;
          state_d = S_PICK;
        end
      end
      S_PICK, S_PROBE: begin
        // A shuffle arriving mid-deal waits until the card is out.
        if (bus.shuffle) pend_d = 1'b1;
        if (counts_q[idx_q] != 6'd0) begin
          counts_d[idx_q] = counts_q[idx_q] - 6'd1;
          rem_d   = rem_q - 9'd1;
          valid_d = 1'b1;
          value_d = value_of(idx_q);
          cdest_d = dest_q;
          state_d = S_IDLE;
        end else begin
          idx_d   = (idx_q == 4'd12) ? 4'd0 : idx_q + 4'd1;
          state_d = S_PROBE;
        end
      end
      S_SHUFFLE: begin
        for (int i = 0; i < 13; i++) counts_d[i] = FULL_COUNT;
        rem_d   = FULL_SHOE;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_NZ;
      for (int i = 0; i < 13; i++) counts_q[i] <= FULL_COUNT;
      rem_q   <= FULL_SHOE;
      idx_q   <= 4'd0;
      dest_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= 4'd0;
      cdest_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      counts_q <= counts_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      dest_q   <= dest_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      cdest_q  <= cdest_d;
    end
  end

  assign bus.deal_ready      = deal_ready;
  assign bus.card_valid      = valid_q;
  assign bus.card_value      = value_q;
  assign bus.card_dest       = cdest_q;
  assign bus.cards_remaining = rem_q;
  assign bus.reshuffle_due   = (rem_q <= CUT);
  assign bus.shoe_empty      = (rem_q == 9'd0);
  assign bus.dbg_state       = state_q;

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
Upstream card source for blackjack_game. Holds a finite shoe of NUM_DECKS standard decks and deals one pseudo-random card per request. Each card goes to the player or dealer input of blackjack_game. Removes dealt cards so rank frequencies are exact, and flags when a reshuffle is due.

Parameters:
NUM_DECKS, 1, decks in shoe; legal 1..8
CUT_REMAIN, 15, reshuffle_due asserts when cards_remaining <= CUT_REMAIN
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
deal_req  in  1  request one card; sampled only when deal_ready=1
deal_dest  in  1  0=player, 1=dealer; captured with deal_req
shuffle  in  1  restore full shoe
deal_ready  out  1  IDLE and shoe not empty
card_valid  out  1  one-cycle pulse, card_value/card_dest valid
card_value  out  4  2..10, ace=11
card_dest  out  1  echo of captured deal_dest
cards_remaining  out  9  undealt cards
reshuffle_due  out  1  cards_remaining <= CUT_REMAIN
shoe_empty  out  1  cards_remaining == 0

Behaviour:
- Reset (async assert, sync release) gives these values:
  - State IDLE, LFSR=SEED.
  - Rank counts full: 4*NUM_DECKS for each of rank idx 0..12. Idx 0..7 are values 2..9, 8..11 are value 10, 12 is ace.
  - cards_remaining=52*NUM_DECKS.
  - card_valid=0, card_value=0, card_dest=0, shuffle pending=0.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances every cycle including during reset release. It never holds 0.
- States: IDLE, PICK, PROBE, SHUFFLE.
- IDLE:
  - If shuffle is high or a shuffle is pending, go to SHUFFLE. A deal_req in that cycle is ignored.
  - Else if deal_req && deal_ready, capture deal_dest and idx = lfsr[3:0]. If that is >=13, subtract 13. Go to PICK.
- PICK/PROBE:
  - If count[idx] > 0: decrement count[idx] and cards_remaining, drive card_value/card_dest, pulse card_valid next cycle, return to IDLE.
  - Else idx = (idx==12)?0:idx+1 and stay in PROBE.
- Latency: card_valid 2 cycles after an accepted request when the first rank is non-empty. Worst case is 14 cycles.
- deal_ready is low in every non-IDLE state and whenever shoe_empty=1.
- card_value and card_dest hold their last values between pulses.
- SHUFFLE: one cycle. Reload all counts and cards_remaining, clear pending, return to IDLE.
- shuffle asserted in PICK/PROBE sets pending. The in-flight deal completes first, then SHUFFLE runs.
- A request while shoe_empty=1 is ignored. No card_valid; the shoe stays empty until shuffle.
- reshuffle_due and shoe_empty are combinational from cards_remaining.
- Deals never reshuffle automatically. Shuffle is owned by the round controller, between rounds.
- Reset mid-deal aborts the deal, refills the shoe and emits no card_valid.

Optional Feature:
Macro CARD_SHOE_FORCE_EN.
- Defined: adds inputs force_en (1) and force_idx (4). If force_en=1 at request acceptance, idx = force_idx (values >=13 treated as 12) instead of the LFSR value. Count and probe rules are unchanged. Intended for directed verification.
- Undefined: ports absent, idx always from LFSR.

Test Plan (all with CARD_SHOE_FORCE_EN, NUM_DECKS=1):
1. Reset with no requests -> cards_remaining=52, deal_ready=1, card_valid=0, reshuffle_due=0, shoe_empty=0.
2. force_idx=12, deal_dest=1, one request -> card_valid exactly 2 cycles later, card_value=11, card_dest=1, cards_remaining=51.
3. Deal force_idx=3 five times -> first four give value 5. The fifth probes: idx 3 is empty, so idx 4 gives value 6 with card_valid 3 cycles after acceptance.
4. Deal 37 cards -> reshuffle_due rises when cards_remaining hits 15. Deal 15 more -> shoe_empty=1, deal_ready=0, and a further deal_req produces no card_valid.
5. Assert shuffle in PROBE -> the pending deal completes, then SHUFFLE runs. cards_remaining=52 one cycle after return to IDLE; shuffle and deal_req together in IDLE -> request dropped.
6. force_en=0, 52 requests from full shoe -> tallies exact: 4 each of values 2..9 and 11, 16 of value 10, no card_valid when empty; assert reset mid-deal -> no pulse, remaining=52.
